// File: rtl/button_event_decoder_pkg.sv
// Shared constants and state encoding for the push-button decoder and its
// sibling board blocks. Provides the BTN_MS_TO_CYCLES ms-to-cycles macro.
`ifndef BTN_MS_TO_CYCLES
`define BTN_MS_TO_CYCLES(ms) ((ms) * (button_event_decoder_pkg::CLK_HZ / 1000))
`endif

package button_event_decoder_pkg;

  localparam int CLK_HZ = 27_000_000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    PRESSED   = 2'd2,
    DEB_REL   = 2'd3
  } btn_state_e;

endpackage

// File: rtl/button_event_decoder_sync_2ff.sv
// Generic two-flop synchroniser for asynchronous board inputs; RST_VAL sets
// the level both flops load on reset.
module button_event_decoder_sync_2ff #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], d};

  always_ff @(posedge clk) begin
    if (rst) sync_q <= {2{RST_VAL}};
    else     sync_q <= sync_d;
  end

  assign q = sync_q[1];

endmodule

// File: rtl/button_event_decoder.sv
// Push-button decoder: synchronise, debounce, classify short/long presses.
// Optional auto-repeat after a long press is enabled by BTN_AUTO_REPEAT_EN.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = `BTN_MS_TO_CYCLES(10),
  parameter int LONG_CYCLES     = `BTN_MS_TO_CYCLES(1000),
  parameter int REPEAT_CYCLES   = `BTN_MS_TO_CYCLES(250),
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HOLD_W = $clog2(LONG_CYCLES) + 1;
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_param_err
    $error("button_event_decoder: cycle parameters out of range");
  end

  logic pin_s, sync_p;

  // Flops reset to the released pin level so reset never looks like a press.
  button_event_decoder_sync_2ff #(.RST_VAL(ACTIVE_LOW)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (pin_s)
  );

  assign sync_p = pin_s ^ ACTIVE_LOW;

  btn_state_e        state_q, state_d;
  logic [DEB_W-1:0]  deb_q, deb_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_seen_q, long_seen_d;
  logic              level, press_ev, short_ev, long_ev;

  // Events are decided combinationally from the current sample so the
  // accepting sample itself counts toward the debounce window.
  always_comb begin
    state_d     = state_q;
    deb_d       = deb_q;
    hold_d      = hold_q;
    long_seen_d = long_seen_q;
    level       = 1'b0;
    press_ev    = 1'b0;
    short_ev    = 1'b0;
    long_ev     = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync_p) begin
          state_d = DEB_PRESS;
          deb_d   = DEB_W'(1);
        end
      end
      DEB_PRESS: begin
        if (!sync_p) begin
          state_d = IDLE;
          deb_d   = '0;
        end else if (deb_q >= DEB_LAST) begin
          state_d     = PRESSED;
          press_ev    = 1'b1;
          level       = 1'b1;
          deb_d       = '0;
          hold_d      = '0;
          long_seen_d = 1'b0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      PRESSED: begin
        level = 1'b1;
        if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
        if (hold_q == LONG_LAST && !long_seen_q) begin
          long_ev     = 1'b1;
          long_seen_d = 1'b1;
        end
        if (!sync_p) begin
          state_d = DEB_REL;
          deb_d   = DEB_W'(1);
        end
      end
      DEB_REL: begin
        level = 1'b1;
        if (sync_p) begin
          state_d = PRESSED;
          deb_d   = '0;
        end else if (deb_q >= DEB_LAST) begin
          state_d  = IDLE;
          level    = 1'b0;
          short_ev = !long_seen_q;
          deb_d    = '0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      deb_q       <= '0;
      hold_q      <= '0;
      long_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_q       <= deb_d;
      hold_q      <= hold_d;
      long_seen_q <= long_seen_d;
    end
  end

  // Outputs are masked while rst is high so an in-flight press emits nothing.
  assign btn_level   = level    & ~rst;
  assign press_pulse = press_ev & ~rst;
  assign short_pulse = short_ev & ~rst;
  assign long_pulse  = long_ev  & ~rst;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             rpt_ev;

  always_comb begin
    rpt_d  = rpt_q;
    rpt_ev = 1'b0;
    if (state_d == IDLE && state_q != IDLE) begin
      rpt_d = '0;
    end else if (state_q == PRESSED && long_seen_q) begin
      if (rpt_q >= RPT_LAST) begin
        rpt_ev = 1'b1;
        rpt_d  = '0;
      end else begin
        rpt_d = rpt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rpt_q <= '0;
    else     rpt_q <= rpt_d;
  end

  assign repeat_pulse = rpt_ev & ~rst;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed cycle-by-cycle bench for button_event_decoder with short debounce
// and hold thresholds; expected waveforms are hand-placed per scenario.
module tb_button_event_decoder;

  localparam int N = 80;

  logic clk = 1'b0;
  logic rst, btn_raw;
  logic btn_level, press_pulse, short_pulse, long_pulse, repeat_pulse;

  int checks = 0;
  int errors = 0;

  logic pin_seq [N];
  logic rst_seq [N];
  logic e_lvl   [N];
  logic e_prs   [N];
  logic e_sht   [N];
  logic e_lng   [N];
  logic e_rpt   [N];

  always #5 clk = ~clk;

  button_event_decoder #(
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (20),
    .REPEAT_CYCLES   (5),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse)
  );

  task automatic clear_seq();
    for (int i = 0; i < N; i++) begin
      pin_seq[i] = 1'b1;
      rst_seq[i] = 1'b0;
      e_lvl[i]   = 1'b0;
      e_prs[i]   = 1'b0;
      e_sht[i]   = 1'b0;
      e_lng[i]   = 1'b0;
      e_rpt[i]   = 1'b0;
    end
  endtask

  task automatic set_pin(input int a, input int b, input logic v);
    for (int i = a; i <= b; i++) pin_seq[i] = v;
  endtask

  task automatic set_lvl(input int a, input int b);
    for (int i = a; i <= b; i++) e_lvl[i] = 1'b1;
  endtask

  task automatic chk(input string tag, input int t, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %b expected %b", tag, t, obs, exp);
    end
  endtask

  // Entered at a negedge. Cycle 0 is the first cycle after the reset edge;
  // outputs are sampled mid-cycle, then that cycle's inputs are driven.
  task automatic run(input string name, input int len);
    rst     = 1'b1;
    btn_raw = 1'b1;
    @(negedge clk);
    for (int t = 0; t < len; t++) begin
      chk({name, ".level"},  t, btn_level,    e_lvl[t]);
      chk({name, ".press"},  t, press_pulse,  e_prs[t]);
      chk({name, ".short"},  t, short_pulse,  e_sht[t]);
      chk({name, ".long"},   t, long_pulse,   e_lng[t]);
      chk({name, ".repeat"}, t, repeat_pulse, e_rpt[t]);
      rst     = rst_seq[t];
      btn_raw = pin_seq[t];
      @(negedge clk);
    end
  endtask

  initial begin
    rst     = 1'b1;
    btn_raw = 1'b1;
    @(negedge clk);

    // Clean short press.
    clear_seq();
    set_pin(10, 24, 1'b0);
    e_prs[15] = 1'b1;
    e_sht[30] = 1'b1;
    set_lvl(15, 29);
    run("short", 40);

    // Bounce every 2 cycles never survives the debounce window.
    clear_seq();
    for (int t = 10; t < 50; t++) pin_seq[t] = (((t - 10) / 2) % 2 == 1);
    run("bounce", 60);

    // Long press, then release with no short event.
    clear_seq();
    set_pin(10, 49, 1'b0);
    e_prs[15] = 1'b1;
    e_lng[35] = 1'b1;
    set_lvl(15, 54);
`ifdef BTN_AUTO_REPEAT_EN
    e_rpt[40] = 1'b1;
    e_rpt[45] = 1'b1;
    e_rpt[50] = 1'b1;
`endif
    run("long", 70);

    // Release bounce: back to PRESSED, long delayed by the 2 frozen cycles.
    clear_seq();
    set_pin(10, 59, 1'b0);
    set_pin(20, 21, 1'b1);
    e_prs[15] = 1'b1;
    e_lng[37] = 1'b1;
    set_lvl(15, 59);
`ifdef BTN_AUTO_REPEAT_EN
    e_rpt[42] = 1'b1;
    e_rpt[47] = 1'b1;
    e_rpt[52] = 1'b1;
    e_rpt[57] = 1'b1;
`endif
    run("relbounce", 60);

    // Reset mid-press: outputs drop, fresh press after full debounce.
    clear_seq();
    set_pin(10, 39, 1'b0);
    rst_seq[20] = 1'b1;
    e_prs[15] = 1'b1;
    e_prs[26] = 1'b1;
    e_sht[45] = 1'b1;
    set_lvl(15, 20);
    set_lvl(26, 44);
    run("midreset", 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
